aui_lane_deskew: RTL and testbench
==================================

# aui_lane_deskew

Receive-side lane alignment for the 16-lane AUI path. It accepts the 1360-bit per-lane words produced by the lane distribution stage, together with each lane's sync flag, and locks onto the alignment-marker word on every lane. It then compensates inter-lane skew of up to `MAX_SKEW` valid beats and presents time-aligned lane words to the downstream RS decode / AM removal stage.

## Interface
- `LANE_WIDTH`, 1360: bits per lane word.
- `NUM_LANES`, 16: number of physical lanes.
- `MAX_SKEW`, 4: maximum tolerated skew, in valid beats, between the earliest and the latest sync arrival.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset.
- `i_valid` in 1: input beat qualifier.
- `i_lanes` in `NUM_LANES*LANE_WIDTH`: lane L occupies bits `[L*LANE_WIDTH +: LANE_WIDTH]`.
- `i_sync` in `NUM_LANES`: per-lane flag marking the AM-bearing word; meaningful only when `i_valid` is high.
- `o_lanes` out `NUM_LANES*LANE_WIDTH`: aligned lane words, same packing as `i_lanes`.
- `o_sync` out 1: the presented beat is the aligned AM word on all lanes.
- `o_valid` out 1: `o_lanes` / `o_sync` are valid this cycle.
- `o_locked` out 1: the block is in LOCKED.
- `o_skew_err` out 1: single-cycle pulse on alignment failure.

## Operation
- A "beat" is a cycle with `i_valid=1`. Cycles without `i_valid` change no state except reset.
- Each lane has a delay line of `MAX_SKEW` words plus sync bits, shifted on every beat. Tap 0 is the current input; tap t>0 is the stored word from t beats earlier.
- The FSM has three states: SEARCH, COLLECT, LOCKED.
- SEARCH: clear the seen-mask and the beat counter.
  - On a beat where any `i_sync` bit is set, record those lanes with arrival 0.
  - If all lanes are set on that beat, lock immediately. Otherwise go to COLLECT with counter = 0.
- COLLECT: on each beat, the counter increments to c, and every newly set lane records arrival c.
  - **Error cases.** Either condition pulses `o_skew_err`, clears the mask and returns to SEARCH; the sync bits of that beat are discarded and do not restart a search:
    - a sync bit on an already-seen lane;
    - c > `MAX_SKEW` with the mask still incomplete.
  - When the mask completes on beat c, tap_L = c − arrival_L. The latest lane gets tap 0; the earliest gets c.
- Lock beat: the taps are computed combinationally and already applied to this beat's output load. `o_lanes` takes the tapped words, and `o_sync=1`, `o_valid=1`, `o_locked=1` take effect next cycle.
- LOCKED: on every beat, `o_lanes` takes the tapped words and `o_sync` takes the AND of the tapped sync bits; `o_valid` pulses next cycle.
  - If the tapped sync bits are mixed (some lanes 1, some 0), the word is not presented. `o_valid` stays 0, `o_skew_err` pulses, `o_locked` clears and the FSM returns to SEARCH.
- Outside LOCKED, `o_valid=0` and `o_lanes` holds its last value.

## Timing
- Reset: when `rst=0` at a clock edge, all outputs are 0 after that edge: `o_lanes`, `o_sync`, `o_valid`, `o_locked`, `o_skew_err`. The FSM is in SEARCH, the delay lines and taps are 0, and the mask is clear. This applies from any state, including mid-COLLECT and LOCKED.
- Latency: a beat at cycle n produces `o_valid` at n+1. A lane with tap t shows the word from t beats before its tap-0 counterpart.
- All outputs are registered; there is no combinational input-to-output path.
- `o_skew_err` is high for exactly one cycle per event, in the cycle after the offending beat. `o_locked` falls in that same cycle.
- Skew exactly `MAX_SKEW` locks; `MAX_SKEW+1` errors.

## Structure
- Shared package `aui_rx_pkg`: `LANE_WIDTH`, `NUM_LANES`, `MAX_SKEW` defaults and the state enum `deskew_state_t` {SEARCH, COLLECT, LOCKED}.
- Sub-module `lane_delay_line`: `MAX_SKEW`-deep shift register of {sync, word} with registered tap select. It is instantiated `NUM_LANES` times.
- The top level holds the FSM, mask, counter, tap computation and output registers.

## Test plan
- **Zero skew.** All 16 `i_sync` bits on beat A → all taps 0; at A+1, `o_valid=1`, `o_sync=1`, `o_locked=1`; the following beats pass with 1-cycle latency.
- **Skew within limit.** Lanes 0–2, 4–6 and 8–15 sync at A; lane 3 at A+2; lane 7 at A+4 → lock on A+4 with taps lane7=0, lane3=2, others=4. At A+5 all presented words are the AM words and `o_sync=1`.
- **Skew over limit.** Lane 9 syncs 5 beats after the rest → `o_skew_err` pulse one cycle after beat A+5 and no lock. A later clean zero-skew sync then locks normally.
- **Valid gaps.** Idle cycles are inserted between COLLECT beats → skew is counted in beats only, and skew 4 spread over 9 cycles still locks.
- **Loss of lock.** While LOCKED, lane 5 alone delivers its next AM one beat late → mixed tapped sync, `o_valid` stays 0, then `o_skew_err` pulses, `o_locked`=0, SEARCH.
- **Reset.** `rst=0` for one cycle mid-COLLECT and again while LOCKED → all outputs 0 after the edge, and a re-lock requires a fresh sync.

Source files
------------

// File: rtl/aui_rx_pkg.sv
// aui_rx_pkg
// Shared definitions for the AUI receive path: default lane geometry,
// the skew budget of the deskew block, and the deskew FSM state type.
// No ports (package).
package aui_rx_pkg;

  localparam int DEFAULT_LANE_WIDTH = 1360;
  localparam int DEFAULT_NUM_LANES  = 16;
  localparam int DEFAULT_MAX_SKEW   = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    COLLECT = 2'd1,
    LOCKED  = 2'd2
  } deskew_state_t;

  // Bits needed to hold the values 0..max_val (at least one bit).
  function automatic int tap_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lane_delay_line.sv
// lane_delay_line
// Per-lane history of {sync, word} for the last DEPTH beats with a
// selectable tap. Tap 0 is the current input, tap t is the entry stored
// t beats ago. The tap is held in a register; on the load cycle the new
// tap value is already used for the output.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   shift         advance the history (one beat)
//   sync_in       sync flag of the current beat
//   word_in       lane word of the current beat
//   tap_load      capture tap_new and use it this cycle
//   tap_new       tap value to load
//   word_out      word at the selected tap
//   sync_out      sync flag at the selected tap
module lane_delay_line #(
  parameter int WIDTH = 1360,
  parameter int DEPTH = 4,
  parameter int TAP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             sync_in,
  input  logic [WIDTH-1:0] word_in,
  input  logic             tap_load,
  input  logic [TAP_W-1:0] tap_new,
  output logic [WIDTH-1:0] word_out,
  output logic             sync_out
);

  logic [WIDTH:0]   line_r [DEPTH];
  logic [TAP_W-1:0] tap_r;
  logic [TAP_W-1:0] sel_s;
  logic [WIDTH:0]   tapped_s;

  // History shift on every beat and tap capture at lock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) line_r[i] <= '0;
      tap_r <= '0;
    end else begin
      if (shift) begin
        line_r[0] <= {sync_in, word_in};
        for (int i = 1; i < DEPTH; i++) line_r[i] <= line_r[i-1];
      end
      if (tap_load) tap_r <= tap_new;
    end
  end

  // Tap multiplexer; a tap being loaded takes effect immediately.
  always_comb begin
    sel_s    = tap_load ? tap_new : tap_r;
    tapped_s = {sync_in, word_in};
    for (int t = 1; t <= DEPTH; t++) begin
      tapped_s = (sel_s == TAP_W'(t)) ? line_r[t-1] : tapped_s;
    end
  end

  assign word_out = tapped_s[WIDTH-1:0];
  assign sync_out = tapped_s[WIDTH];

endmodule

// File: rtl/aui_lane_deskew.sv
// aui_lane_deskew
// Receive-side lane alignment for the AUI path. Finds the AM-bearing word
// on every lane, measures each lane's arrival (in beats) relative to the
// latest lane, and delays the early lanes so all lanes present their AM
// word on the same output beat. Loses lock when the tapped sync flags
// disagree.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   i_valid      input beat qualifier
//   i_lanes      NUM_LANES packed lane words (lane L at [L*LANE_WIDTH +: LANE_WIDTH])
//   i_sync       per-lane AM flag
//   o_lanes      aligned lane words, same packing
//   o_sync       presented beat is the aligned AM word
//   o_valid      o_lanes / o_sync valid this cycle
//   o_locked     block is aligned
//   o_skew_err   one-cycle pulse on alignment failure
module aui_lane_deskew
  import aui_rx_pkg::*;
#(
  parameter int LANE_WIDTH = DEFAULT_LANE_WIDTH,
  parameter int NUM_LANES  = DEFAULT_NUM_LANES,
  parameter int MAX_SKEW   = DEFAULT_MAX_SKEW
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] i_lanes,
  input  logic [NUM_LANES-1:0]            i_sync,
  output logic [NUM_LANES*LANE_WIDTH-1:0] o_lanes,
  output logic                            o_sync,
  output logic                            o_valid,
  output logic                            o_locked,
  output logic                            o_skew_err
);

  localparam int TAP_W = tap_width(MAX_SKEW);
  // The counter must reach MAX_SKEW+1 to detect an overflow.
  localparam int CNT_W = tap_width(MAX_SKEW + 1);
  localparam logic [CNT_W-1:0] SKEW_LIMIT = CNT_W'(MAX_SKEW);

  deskew_state_t                 state_r, state_s;
  logic [NUM_LANES-1:0]          mask_r, mask_s, seen_s, tapped_sync_s;
  logic [CNT_W-1:0]              cnt_r, cnt_s, c_s;
  logic [CNT_W-1:0]              arr_r [NUM_LANES];
  logic [CNT_W-1:0]              arr_s [NUM_LANES];
  logic [TAP_W-1:0]              tap_new_s [NUM_LANES];
  logic [LANE_WIDTH-1:0]         tapped_word_s [NUM_LANES];
  logic [NUM_LANES*LANE_WIDTH-1:0] lanes_s;
  logic dup_s, overflow_s, lock_search_s, lock_collect_s, tap_load_s;
  logic present_s, sync_out_s, err_s;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_delay_line #(
      .WIDTH (LANE_WIDTH),
      .DEPTH (MAX_SKEW),
      .TAP_W (TAP_W)
    ) u_dly (
      .clk      (clk),
      .rst      (rst),
      .shift    (i_valid),
      .sync_in  (i_sync[g]),
      .word_in  (i_lanes[g*LANE_WIDTH +: LANE_WIDTH]),
      .tap_load (tap_load_s),
      .tap_new  (tap_new_s[g]),
      .word_out (tapped_word_s[g]),
      .sync_out (tapped_sync_s[g])
    );
    assign lanes_s[g*LANE_WIDTH +: LANE_WIDTH] = tapped_word_s[g];
  end

  // Arrival bookkeeping and lock/tap computation. Kept apart from the FSM
  // so the tap select never depends on the tapped sync bits.
  always_comb begin
    c_s            = cnt_r + CNT_W'(1);
    seen_s         = mask_r | i_sync;
    dup_s          = |(mask_r & i_sync);
    overflow_s     = (c_s > SKEW_LIMIT);
    lock_search_s  = (state_r == SEARCH) && i_valid && (&i_sync);
    lock_collect_s = (state_r == COLLECT) && i_valid && !dup_s && !overflow_s && (&seen_s);
    tap_load_s     = lock_search_s || lock_collect_s;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (state_r == SEARCH) begin
        arr_s[l] = '0;
      end else if ((state_r == COLLECT) && i_valid && i_sync[l]) begin
        arr_s[l] = c_s;
      end else begin
        arr_s[l] = arr_r[l];
      end
      // Latest lane (arrival c) gets tap 0, earliest gets c.
      tap_new_s[l] = lock_collect_s ? TAP_W'(c_s - arr_s[l]) : '0;
    end
  end

  // FSM next state and presentation decisions.
  always_comb begin
    state_s    = state_r;
    mask_s     = mask_r;
    cnt_s      = cnt_r;
    present_s  = 1'b0;
    sync_out_s = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      SEARCH: begin
        mask_s = '0;
        cnt_s  = '0;
        if (i_valid && (|i_sync)) begin
          mask_s = i_sync;
          if (lock_search_s) begin
            state_s    = LOCKED;
            present_s  = 1'b1;
            sync_out_s = 1'b1;
          end else begin
            state_s = COLLECT;
          end
        end else begin
          state_s = SEARCH;
        end
      end
      COLLECT: begin
        if (!i_valid) begin
          state_s = COLLECT;
        end else if (dup_s || overflow_s) begin
          // The offending beat's sync bits are dropped, not re-searched.
          err_s   = 1'b1;
          mask_s  = '0;
          cnt_s   = '0;
          state_s = SEARCH;
        end else begin
          mask_s = seen_s;
          cnt_s  = c_s;
          if (lock_collect_s) begin
            state_s    = LOCKED;
            present_s  = 1'b1;
            sync_out_s = 1'b1;
          end else begin
            state_s = COLLECT;
          end
        end
      end
      LOCKED: begin
        if (!i_valid) begin
          state_s = LOCKED;
        end else if ((&tapped_sync_s) || !(|tapped_sync_s)) begin
          present_s  = 1'b1;
          sync_out_s = &tapped_sync_s;
        end else begin
          // Lanes disagree on where the AM is: alignment is lost.
          err_s   = 1'b1;
          mask_s  = '0;
          cnt_s   = '0;
          state_s = SEARCH;
        end
      end
      default: begin
        state_s = SEARCH;
        mask_s  = '0;
        cnt_s   = '0;
      end
    endcase
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= SEARCH;
      mask_r     <= '0;
      cnt_r      <= '0;
      for (int l = 0; l < NUM_LANES; l++) arr_r[l] <= '0;
      o_lanes    <= '0;
      o_sync     <= 1'b0;
      o_valid    <= 1'b0;
      o_locked   <= 1'b0;
      o_skew_err <= 1'b0;
    end else begin
      state_r    <= state_s;
      mask_r     <= mask_s;
      cnt_r      <= cnt_s;
      for (int l = 0; l < NUM_LANES; l++) arr_r[l] <= arr_s[l];
      o_sync     <= sync_out_s;
      o_valid    <= present_s;
      o_locked   <= (state_s == LOCKED);
      o_skew_err <= err_s;
      if (present_s) o_lanes <= lanes_s;
    end
  end

endmodule

// File: tb/tb_aui_lane_deskew.sv
// tb_aui_lane_deskew
// Directed scenarios plus randomized rounds. Lane words are random; each
// lane's AM flag recurs every P beats at a per-lane offset. A reference
// model tracks beat history and arrival beat numbers to predict outputs.
module tb_aui_lane_deskew;
  import aui_rx_pkg::*;

  localparam int LW = DEFAULT_LANE_WIDTH;
  localparam int NL = DEFAULT_NUM_LANES;
  localparam int MS = DEFAULT_MAX_SKEW;
  localparam int BW = NL * LW;
  localparam int P  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic [BW-1:0] i_lanes;
  logic [NL-1:0] i_sync;
  logic [BW-1:0] o_lanes;
  logic          o_sync, o_valid, o_locked, o_skew_err;

  aui_lane_deskew #(.LANE_WIDTH(LW), .NUM_LANES(NL), .MAX_SKEW(MS)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_lanes(i_lanes), .i_sync(i_sync),
    .o_lanes(o_lanes), .o_sync(o_sync), .o_valid(o_valid), .o_locked(o_locked),
    .o_skew_err(o_skew_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [BW-1:0] hist_w[$];
  logic [NL-1:0] hist_s[$];
  int mode;            // 0 searching, 1 gathering arrivals, 2 aligned
  int first_b;
  int arr_b[NL];
  int tap_m[NL];
  logic exp_valid, exp_sync, exp_locked, exp_err;
  logic [BW-1:0] exp_lanes;

  // Stimulus state
  int off[NL];
  int g;
  logic [LW-1:0] am0, am3, am7;

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] v;
    for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic show(input int b, input logic sy);
    exp_valid = 1'b1;
    exp_sync  = sy;
    for (int l = 0; l < NL; l++)
      exp_lanes[l*LW +: LW] = hist_w[b - tap_m[l]][l*LW +: LW];
  endtask

  task automatic lock_at(input int b);
    for (int l = 0; l < NL; l++) tap_m[l] = b - arr_b[l];
    mode = 2;
    show(b, 1'b1);
  endtask

  task automatic model_step(input logic v, input logic [NL-1:0] s, input logic [BW-1:0] w);
    int b, ones;
    bit dup, all;
    exp_valid = 1'b0;
    exp_sync  = 1'b0;
    exp_err   = 1'b0;
    if (!rst) begin
      mode = 0;
      hist_w.delete();
      hist_s.delete();
      exp_locked = 1'b0;
      exp_lanes  = '0;
    end else if (v) begin
      hist_w.push_back(w);
      hist_s.push_back(s);
      b = hist_w.size() - 1;
      case (mode)
        0: if (s != '0) begin
          first_b = b;
          for (int l = 0; l < NL; l++) arr_b[l] = s[l] ? b : -1;
          if (&s) lock_at(b); else mode = 1;
        end
        1: begin
          dup = 0;
          for (int l = 0; l < NL; l++) if (s[l] && arr_b[l] >= 0) dup = 1;
          if (dup || (b - first_b) > MS) begin
            exp_err = 1'b1;
            mode = 0;
          end else begin
            all = 1;
            for (int l = 0; l < NL; l++) begin
              if (s[l]) arr_b[l] = b;
              if (arr_b[l] < 0) all = 0;
            end
            if (all) lock_at(b);
          end
        end
        default: begin
          ones = 0;
          for (int l = 0; l < NL; l++) if (hist_s[b - tap_m[l]][l]) ones++;
          if (ones == 0 || ones == NL) show(b, ones == NL);
          else begin
            exp_err = 1'b1;
            mode = 0;
          end
        end
      endcase
      exp_locked = (mode == 2);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (low 64 bits)", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic chk_lanes();
    int fl;
    fl = 0;
    n_assert++;
    assert (o_lanes === exp_lanes) else begin
      n_fail++;
      for (int l = NL - 1; l >= 0; l--)
        if (o_lanes[l*LW +: LW] !== exp_lanes[l*LW +: LW]) fl = l;
      $error("FAIL lanes: lane %0d observed %h expected %h (low 64 bits)",
             fl, o_lanes[fl*LW +: 64], exp_lanes[fl*LW +: 64]);
    end
  endtask

  // One clock cycle: drive, clock, predict, compare.
  task automatic tick(input logic v);
    logic [NL-1:0] s;
    for (int l = 0; l < NL; l++) s[l] = (g >= off[l]) && (((g - off[l]) % P) == 0);
    i_valid = v;
    i_sync  = v ? s : NL'($urandom());
    i_lanes = rand_bus();
    @(posedge clk);
    #1;
    model_step(i_valid, i_sync, i_lanes);
    if (v) g++;
    chk1("valid", o_valid, exp_valid);
    chk1("locked", o_locked, exp_locked);
    chk1("skew_err", o_skew_err, exp_err);
    if (exp_valid) chk1("sync", o_sync, exp_sync);
    chk_lanes();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1'b1);
    rst = 1'b1;
    g = 0;
    chk1("rst_valid", o_valid, 1'b0);
    chk1("rst_sync", o_sync, 1'b0);
    chk1("rst_locked", o_locked, 1'b0);
    chk1("rst_err", o_skew_err, 1'b0);
    n_assert++;
    assert (o_lanes === '0) else begin
      n_fail++;
      $error("FAIL rst_lanes: observed nonzero low %h expected 0", o_lanes[63:0]);
    end
  endtask

  task automatic set_off(input int v);
    for (int l = 0; l < NL; l++) off[l] = v;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_sync = '0; i_lanes = '0;
    g = 0; mode = 0; exp_lanes = '0;
    exp_valid = 1'b0; exp_sync = 1'b0; exp_locked = 1'b0; exp_err = 1'b0;
    set_off(0);

    do_reset();
    tick(1'b0);
    tick(1'b0);

    // Zero skew
    set_off(0);
    for (int k = 0; k < 25; k++) begin
      tick(1'b1);
      if (k == 0) begin
        chk1("zs_valid", o_valid, 1'b1);
        chk1("zs_sync", o_sync, 1'b1);
        chk1("zs_locked", o_locked, 1'b1);
      end
    end

    // Reset while locked; no lock without a fresh sync
    do_reset();
    set_off(1000);
    for (int k = 0; k < 12; k++) tick(1'b1);
    chk1("nosync_locked", o_locked, 1'b0);

    // Reset mid-collect
    do_reset();
    set_off(0);
    off[7] = 4;
    tick(1'b1);
    tick(1'b1);
    chk1("mc_locked", o_locked, 1'b0);
    do_reset();

    // Skew within limit, then loss of lock on lane 5
    set_off(0);
    off[3] = 2;
    off[7] = 4;
    for (int k = 0; k < 40; k++) begin
      tick(1'b1);
      if (k == 0) am0 = i_lanes[0 +: LW];
      if (k == 2) am3 = i_lanes[3*LW +: LW];
      if (k == 3) chk1("sk_prelock", o_locked, 1'b0);
      if (k == 4) begin
        am7 = i_lanes[7*LW +: LW];
        chk1("sk_sync", o_sync, 1'b1);
        chk1("sk_locked", o_locked, 1'b1);
        chk_word("sk_lane0", o_lanes[0 +: LW], am0);
        chk_word("sk_lane3", o_lanes[3*LW +: LW], am3);
        chk_word("sk_lane7", o_lanes[7*LW +: LW], am7);
      end
      if (k == 12) off[5] = 1;
      if (k == 24) begin
        chk1("lol_valid", o_valid, 1'b0);
        chk1("lol_err", o_skew_err, 1'b1);
        chk1("lol_locked", o_locked, 1'b0);
      end
    end

    // Skew over limit, then a clean zero-skew lock
    do_reset();
    set_off(0);
    off[9] = 5;
    for (int k = 0; k < 30; k++) begin
      tick(1'b1);
      if (k == 5) begin
        chk1("ov_err", o_skew_err, 1'b1);
        chk1("ov_locked", o_locked, 1'b0);
        off[9] = 0;
      end
      if (k == 10) chk1("ov_relock", o_locked, 1'b1);
    end

    // Valid gaps: skew 4 spread over 9 cycles
    do_reset();
    set_off(0);
    off[0] = 4;
    for (int k = 0; k < 12; k++) begin
      tick(1'b1);
      if (k == 4) chk1("gap_locked", o_locked, 1'b1);
      tick(1'b0);
    end

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int l = 0; l < NL; l++) off[l] = $urandom_range(0, MS);
      if (r == 2) off[$urandom_range(0, NL - 1)] = MS + 1;
      for (int k = 0; k < 40; k++) begin
        tick(1'b1);
        if ($urandom_range(0, 3) == 0) tick(1'b0);
        if (k == 20) off[$urandom_range(0, NL - 1)] += 1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
